// File: rtl/exception_unit.sv
// Exception responder: detects EX overflow and ID reserved-instruction faults,
// redirects fetch, flushes the pipeline, and holds EPC/Cause/EXL plus an exception counter.
module exception_unit #(
    parameter logic [4:0] RI_CODE = 5'd10,
    parameter logic [4:0] OV_CODE = 5'd12,
    parameter int         CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [31:0]      exceptAddr,
    input  logic [31:0]      ID_PC,
    input  logic             ID_Valid,
    input  logic             ID_Undefined,
    input  logic             ID_Eret,
    input  logic [31:0]      EX_PC,
    input  logic             EX_Valid,
    input  logic             EX_Overflow,
    output logic [31:0]      EPC,
    output logic [31:0]      Cause,
    output logic             EXL,
    output logic             PCRedirect,
    output logic [31:0]      PCRedirectAddr,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             EX_Flush,
    output logic [CNT_W-1:0] ExcCount
);

    typedef enum logic {NORMAL, HANDLER} state_t;

    state_t           state, state_nxt;
    logic [31:0]      epc_q, epc_nxt;
    logic [4:0]       code_q, code_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             ex_ex, id_ex, eret;

    assign ex_ex = EX_Valid & EX_Overflow;
    assign id_ex = ID_Valid & ID_Undefined;
    assign eret  = ID_Valid & ID_Eret;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= NORMAL;
            epc_q  <= '0;
            code_q <= '0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            epc_q  <= epc_nxt;
            code_q <= code_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        epc_nxt        = epc_q;
        code_nxt       = code_q;
        cnt_nxt        = cnt_q;
        PCRedirect     = 1'b0;
        PCRedirectAddr = exceptAddr;
        IF_Flush       = 1'b0;
        ID_Flush       = 1'b0;
        EX_Flush       = 1'b0;

        // Older instruction wins; a nested fault keeps the original EPC.
        if (ex_ex || id_ex) begin
            PCRedirect = 1'b1;
            IF_Flush   = 1'b1;
            ID_Flush   = 1'b1;
            EX_Flush   = ex_ex;
            code_nxt   = ex_ex ? OV_CODE : RI_CODE;
            if (state == NORMAL) epc_nxt = ex_ex ? EX_PC : ID_PC;
            state_nxt  = HANDLER;
            cnt_nxt    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        end else if (eret) begin
            PCRedirect     = 1'b1;
            PCRedirectAddr = epc_q;
            IF_Flush       = 1'b1;
            ID_Flush       = 1'b1;
            state_nxt      = NORMAL;
        end

        // Reset kills any pending redirect without waiting for an edge.
        if (Reset) begin
            PCRedirect     = 1'b0;
            PCRedirectAddr = '0;
            IF_Flush       = 1'b0;
            ID_Flush       = 1'b0;
            EX_Flush       = 1'b0;
        end
    end

    assign EPC      = epc_q;
    assign Cause    = {25'b0, code_q, 2'b00};
    assign EXL      = (state == HANDLER);
    assign ExcCount = cnt_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: hand-computed expectations checked with immediate assertions.
module tb_exception_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] exceptAddr, ID_PC, EX_PC;
    logic        ID_Valid, ID_Undefined, ID_Eret, EX_Valid, EX_Overflow;
    logic [31:0] EPC, Cause, PCRedirectAddr;
    logic        EXL, PCRedirect, IF_Flush, ID_Flush, EX_Flush;
    logic [7:0]  ExcCount;

    int total = 0;
    int bad   = 0;

    exception_unit dut (
        .CLK(CLK), .Reset(Reset), .exceptAddr(exceptAddr),
        .ID_PC(ID_PC), .ID_Valid(ID_Valid), .ID_Undefined(ID_Undefined), .ID_Eret(ID_Eret),
        .EX_PC(EX_PC), .EX_Valid(EX_Valid), .EX_Overflow(EX_Overflow),
        .EPC(EPC), .Cause(Cause), .EXL(EXL), .PCRedirect(PCRedirect),
        .PCRedirectAddr(PCRedirectAddr), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush),
        .EX_Flush(EX_Flush), .ExcCount(ExcCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ID_Valid = 0; ID_Undefined = 0; ID_Eret = 0;
        EX_Valid = 0; EX_Overflow = 0;
    endtask

    // Combinational redirect/flush outputs
    task automatic chk_ctl(input string tag, input logic r, input logic [31:0] a,
                           input logic f_if, input logic f_id, input logic f_ex);
        chk({tag, ".redir"}, {31'b0, PCRedirect}, {31'b0, r});
        chk({tag, ".addr"}, PCRedirectAddr, a);
        chk({tag, ".ifflush"}, {31'b0, IF_Flush}, {31'b0, f_if});
        chk({tag, ".idflush"}, {31'b0, ID_Flush}, {31'b0, f_id});
        chk({tag, ".exflush"}, {31'b0, EX_Flush}, {31'b0, f_ex});
    endtask

    // Architectural state
    task automatic chk_st(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                          input logic exl, input int cnt);
        chk({tag, ".epc"}, EPC, epc);
        chk({tag, ".cause"}, Cause, cause);
        chk({tag, ".exl"}, {31'b0, EXL}, {31'b0, exl});
        chk({tag, ".cnt"}, {24'b0, ExcCount}, cnt[31:0]);
    endtask

    initial begin
        Reset = 1; exceptAddr = 32'h500; ID_PC = 0; EX_PC = 0;
        idle();
        #12;
        chk_ctl("rst", 0, 32'h0, 0, 0, 0);
        chk_st("rst", 0, 0, 0, 0);
        Reset = 0;

        // Reserved instruction in ID
        step();
        ID_Valid = 1; ID_Undefined = 1; ID_PC = 32'h308;
        #1 chk_ctl("ri", 1, 32'h500, 1, 1, 0);
        step();
        idle();
        chk_st("ri", 32'h308, 32'h28, 1, 1);

        // eret back to 0x308, leaves handler
        ID_Valid = 1; ID_Eret = 1;
        #1 chk_ctl("eret1", 1, 32'h308, 1, 1, 0);
        step();
        idle();
        chk_st("eret1", 32'h308, 32'h28, 0, 1);

        // Overflow and RI in same cycle: EX wins
        EX_Valid = 1; EX_Overflow = 1; EX_PC = 32'h314;
        ID_Valid = 1; ID_Undefined = 1; ID_PC = 32'h318;
        #1 chk_ctl("prio", 1, 32'h500, 1, 1, 1);
        step();
        idle();
        chk_st("prio", 32'h314, 32'h30, 1, 2);

        // Nested RI, then nested overflow: EPC preserved
        ID_Valid = 1; ID_Undefined = 1; ID_PC = 32'h400;
        step();
        idle();
        chk_st("nest_ri", 32'h314, 32'h28, 1, 3);
        EX_Valid = 1; EX_Overflow = 1; EX_PC = 32'h52C;
        step();
        idle();
        chk_st("nest_ov", 32'h314, 32'h30, 1, 4);

        // Leave, then fault at 0x52C from NORMAL
        ID_Valid = 1; ID_Eret = 1;
        step();
        idle();
        chk_st("eret2", 32'h314, 32'h30, 0, 4);
        EX_Valid = 1; EX_Overflow = 1; EX_PC = 32'h52C;
        step();
        idle();
        chk_st("ov52c", 32'h52C, 32'h30, 1, 5);

        // eret with simultaneous overflow: exception wins, EXL stays 1
        ID_Valid = 1; ID_Eret = 1; EX_Valid = 1; EX_Overflow = 1; EX_PC = 32'h600;
        #1 chk_ctl("eret_ov", 1, 32'h500, 1, 1, 1);
        step();
        idle();
        chk_st("eret_ov", 32'h52C, 32'h30, 1, 6);

        // Plain eret to 0x52C
        ID_Valid = 1; ID_Eret = 1;
        #1 chk_ctl("eret3", 1, 32'h52C, 1, 1, 0);
        step();
        idle();
        chk_st("eret3", 32'h52C, 32'h30, 0, 6);

        // Enter handler, then pulse reset mid-cycle with exEx still active
        EX_Valid = 1; EX_Overflow = 1; EX_PC = 32'h700;
        step();
        chk_st("pre_rst", 32'h700, 32'h30, 1, 7);
        chk_ctl("pre_rst", 1, 32'h500, 1, 1, 1);
        Reset = 1;
        #1 chk_ctl("rst_pulse", 0, 32'h0, 0, 0, 0);
        chk_st("rst_pulse", 0, 0, 0, 0);
        #2 chk("rst_pulse.redir_late", {31'b0, PCRedirect}, 32'h0);
        #1 Reset = 0;
        idle();
        #1 chk_ctl("post_rst", 0, 32'h500, 0, 0, 0);

        // Invalid ID instruction is ignored
        step();
        ID_Valid = 0; ID_Undefined = 1; ID_Eret = 1; ID_PC = 32'h800;
        #1 chk_ctl("novalid", 0, 32'h500, 0, 0, 0);
        step();
        idle();
        chk_st("novalid", 0, 0, 0, 0);

        // eret in NORMAL: redirect to EPC, EXL stays 0
        ID_Valid = 1; ID_Eret = 1;
        #1 chk_ctl("eret_norm", 1, 32'h0, 1, 1, 0);
        step();
        idle();
        chk_st("eret_norm", 0, 0, 0, 0);

        // Back-to-back exceptions saturate the counter
        EX_Valid = 1; EX_Overflow = 1; EX_PC = 32'h900;
        repeat (254) @(posedge CLK);
        #1 chk("sat254", {24'b0, ExcCount}, 32'd254);
        repeat (6) @(posedge CLK);
        #1 idle();
        chk_st("sat", 32'h900, 32'h30, 1, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
